// File: rtl/dma_timing_fsm_pkg.sv
// Shared state and mode encodings for the DMA service/bus-cycle engine.
// Helper functions group states by which bus signals they own.
package dma_timing_fsm_pkg;

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        SC = 3'd2,
        S1 = 3'd3,
        S2 = 3'd4,
        S3 = 3'd5,
        SW = 3'd6,
        S4 = 3'd7
    } dma_state_t;

    localparam logic [1:0] MODE_DEMAND  = 2'b00;
    localparam logic [1:0] MODE_SINGLE  = 2'b01;
    localparam logic [1:0] MODE_BLOCK   = 2'b10;
    localparam logic [1:0] MODE_CASCADE = 2'b11;

    localparam logic [1:0] XFER_VERIFY = 2'b00;
    localparam logic [1:0] XFER_WRITE  = 2'b01;
    localparam logic [1:0] XFER_READ   = 2'b10;

    // States in which losing HLDA aborts the transfer
    function automatic logic in_bus_cycle(input dma_state_t s);
        return (s == S1) || (s == S2) || (s == S3) || (s == SW);
    endfunction

    // States in which the controller owns the address bus
    function automatic logic drives_address(input dma_state_t s);
        return in_bus_cycle(s) || (s == S4);
    endfunction

endpackage

// File: rtl/dma_timing_fsm.sv
// 8237-style service engine: HRQ/HLDA handshake, S0-S4 transfer timing,
// registered bus strobes, DACK/AEN/ADSTB and datapath update pulses.
module dma_timing_fsm
    import dma_timing_fsm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    input  logic [CH_W-1:0]   req_ch,
    input  logic              req_active,
    input  logic [7:0]        mode_reg,
    input  logic              cmd_ctim,
    input  logic              cmd_dack_al,
    input  logic              HLDA,
    input  logic              READY,
    input  logic              EOP_N_in,
    input  logic              count_zero,
    input  logic              addr_hi_chg,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              AEN,
    output logic              ADSTB,
    output logic              MEMR_N,
    output logic              MEMW_N,
    output logic              IOR_N,
    output logic              IOW_N,
    output logic              EOP_N_out,
    output logic              cnt_upd,
    output logic              svc_done,
    output logic [2:0]        state_dbg
);

    dma_state_t          state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [1:0]          op_mode_q, op_mode_d;
    logic [1:0]          xfer_q, xfer_d;
    logic                ext_eop_q, ext_eop_d;
    logic                hrq_q, hrq_d;
    logic                aen_q, aen_d;
    logic                adstb_q, adstb_d;
    logic [NUM_CH-1:0]   dack_q, dack_d;
    logic                memr_n_q, memr_n_d;
    logic                memw_n_q, memw_n_d;
    logic                ior_n_q, ior_n_d;
    logic                iow_n_q, iow_n_d;
    logic                eop_n_q, eop_n_d;
    logic                cnt_upd_q, cnt_upd_d;
    logic                svc_done_q, svc_done_d;

    logic                xfer_end;
    logic                svc_end;
    logic                rd_low;
    logic                wr_low;
    logic                unused_mode_bits;

    assign unused_mode_bits = ^{mode_reg[5:4], mode_reg[1:0]};

    // Next-state logic. eop_n_q low in S4 is the TC latched on S4 entry.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        op_mode_d = op_mode_q;
        xfer_d    = xfer_q;
        svc_end   = 1'b0;
        xfer_end  = !eop_n_q || ext_eop_q || !EOP_N_in || !HLDA
                    || (op_mode_q == MODE_SINGLE)
                    || ((op_mode_q == MODE_DEMAND) && !req_active);

        case (state_q)
            SI: begin
                ch_d      = req_ch;
                op_mode_d = mode_reg[7:6];
                xfer_d    = mode_reg[3:2];
                if (req_valid) state_d = S0;
            end
            S0: begin
                ch_d      = req_ch;
                op_mode_d = mode_reg[7:6];
                xfer_d    = mode_reg[3:2];
                if (HLDA) begin
                    state_d = (mode_reg[7:6] == MODE_CASCADE) ? SC : S1;
                end else if (!req_valid) begin
                    state_d = SI;
                end
            end
            SC: begin
                if (!HLDA || !req_active) begin
                    state_d = SI;
                    svc_end = 1'b1;
                end
            end
            S1: state_d = S2;
            S2: begin
                if (cmd_ctim) state_d = READY ? S4 : SW;
                else          state_d = S3;
            end
            S3: state_d = READY ? S4 : SW;
            SW: if (READY) state_d = S4;
            S4: begin
                if (xfer_end) begin
                    state_d = SI;
                    svc_end = 1'b1;
                end else begin
                    state_d = S1;
                end
            end
            default: state_d = SI;
        endcase

        if (in_bus_cycle(state_q) && !HLDA) begin
            state_d = SI;
            svc_end = 1'b1;
        end
    end

    // Registered outputs are decoded from the next state so they line up with it
    always_comb begin
        rd_low     = (state_d == S2) || (state_d == S3) || (state_d == SW);
        wr_low     = (state_d == S3) || (state_d == SW) || (cmd_ctim && (state_d == S2));
        hrq_d      = (state_d != SI);
        aen_d      = drives_address(state_d);
        adstb_d    = (state_d == S1) && ((state_q == S0) || addr_hi_chg);
        dack_d     = '0;
        if ((state_d == SC) || drives_address(state_d)) dack_d[ch_d] = 1'b1;
        memr_n_d   = !(rd_low && (xfer_d == XFER_READ));
        ior_n_d    = !(rd_low && (xfer_d == XFER_WRITE));
        memw_n_d   = !(wr_low && (xfer_d == XFER_WRITE));
        iow_n_d    = !(wr_low && (xfer_d == XFER_READ));
        eop_n_d    = !((state_d == S4) && count_zero);
        cnt_upd_d  = (state_d == S4);
        svc_done_d = svc_end;

        ext_eop_d = ext_eop_q;
        if (((state_q == S2) || (state_q == S3) || (state_q == SW)) && !EOP_N_in) begin
            ext_eop_d = 1'b1;
        end else if ((state_q == S4) || (state_q == SI) || (state_q == S0)) begin
            ext_eop_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= SI;
            ch_q       <= '0;
            op_mode_q  <= MODE_DEMAND;
            xfer_q     <= XFER_VERIFY;
            ext_eop_q  <= 1'b0;
            hrq_q      <= 1'b0;
            aen_q      <= 1'b0;
            adstb_q    <= 1'b0;
            dack_q     <= '0;
            memr_n_q   <= 1'b1;
            memw_n_q   <= 1'b1;
            ior_n_q    <= 1'b1;
            iow_n_q    <= 1'b1;
            eop_n_q    <= 1'b1;
            cnt_upd_q  <= 1'b0;
            svc_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            op_mode_q  <= op_mode_d;
            xfer_q     <= xfer_d;
            ext_eop_q  <= ext_eop_d;
            hrq_q      <= hrq_d;
            aen_q      <= aen_d;
            adstb_q    <= adstb_d;
            dack_q     <= dack_d;
            memr_n_q   <= memr_n_d;
            memw_n_q   <= memw_n_d;
            ior_n_q    <= ior_n_d;
            iow_n_q    <= iow_n_d;
            eop_n_q    <= eop_n_d;
            cnt_upd_q  <= cnt_upd_d;
            svc_done_q <= svc_done_d;
        end
    end

    // DACK is held active-high internally; polarity is applied at the pins
    assign DACK      = dack_q ^ {NUM_CH{cmd_dack_al}};
    assign HRQ       = hrq_q;
    assign AEN       = aen_q;
    assign ADSTB     = adstb_q;
    assign MEMR_N    = memr_n_q;
    assign MEMW_N    = memw_n_q;
    assign IOR_N     = ior_n_q;
    assign IOW_N     = iow_n_q;
    assign EOP_N_out = eop_n_q;
    assign cnt_upd   = cnt_upd_q;
    assign svc_done  = svc_done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dma_timing_fsm.sv
// Bench for dma_timing_fsm: per-cycle vector tables through an expected-value
// queue, randomized verify transfers, and hand-written reset sequences.
module tb_dma_timing_fsm;
    import dma_timing_fsm_pkg::*;

    // stim = {req_valid, HLDA, READY, req_active, EOP_N_in, addr_hi_chg}
    // exp  = {HRQ, AEN, ADSTB, MEMR_N, IOR_N, MEMW_N, IOW_N, EOP_N_out, cnt_upd, svc_done, DACK[3:0]}
    typedef struct {
        logic [5:0]  stim;
        logic [13:0] exp;
    } vec_t;

    localparam logic [13:0] IDLE0 = 14'b000_1111_100_0000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_ch = 2'd0;
    logic        req_active = 1'b1;
    logic [7:0]  mode_reg = 8'h00;
    logic        cmd_ctim = 1'b0;
    logic        cmd_dack_al = 1'b0;
    logic        HLDA = 1'b0;
    logic        READY = 1'b1;
    logic        EOP_N_in = 1'b1;
    logic        count_zero;
    logic        addr_hi_chg = 1'b0;
    logic        HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_out, cnt_upd, svc_done;
    logic [3:0]  DACK;
    logic [2:0]  state_dbg;

    logic [13:0] act_w;
    logic [13:0] exp_q[$];
    vec_t        tbl[$];
    logic [15:0] cnt = 16'd5;
    int          n_vec = 0;
    int          n_err = 0;
    int          row_idx = 0;
    string       scen = "";

    dma_timing_fsm #(.NUM_CH(4), .CH_W(2)) dut (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ch(req_ch),
        .req_active(req_active), .mode_reg(mode_reg), .cmd_ctim(cmd_ctim),
        .cmd_dack_al(cmd_dack_al), .HLDA(HLDA), .READY(READY), .EOP_N_in(EOP_N_in),
        .count_zero(count_zero), .addr_hi_chg(addr_hi_chg), .HRQ(HRQ), .DACK(DACK),
        .AEN(AEN), .ADSTB(ADSTB), .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N),
        .IOW_N(IOW_N), .EOP_N_out(EOP_N_out), .cnt_upd(cnt_upd), .svc_done(svc_done),
        .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    assign count_zero = (cnt == 16'd0);
    assign act_w = {HRQ, AEN, ADSTB, MEMR_N, IOR_N, MEMW_N, IOW_N, EOP_N_out, cnt_upd, svc_done, DACK};

    task automatic drive(input logic [5:0] s);
        {req_valid, HLDA, READY, req_active, EOP_N_in, addr_hi_chg} = s;
    endtask

    task automatic check(input string what, input logic [13:0] got, input logic [13:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", what, got, want);
        end
    endtask

    // Pops one expectation; also plays the word counter on each cnt_upd pulse
    task automatic sb_pop();
        logic [13:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s row %0d", scen, row_idx), act_w, e);
            row_idx++;
        end
        if (cnt_upd) cnt = cnt - 16'd1;
    endtask

    task automatic add(input logic [5:0] s, input logic [13:0] e);
        vec_t v;
        v.stim = s;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string name);
        scen    = name;
        row_idx = 0;
        foreach (tbl[i]) begin
            @(negedge CLK);
            sb_pop();
            drive(tbl[i].stim);
            exp_q.push_back(tbl[i].exp);
        end
        @(negedge CLK);
        sb_pop();
        tbl.delete();
    endtask

    task automatic setup(input logic [1:0] ch, input logic [7:0] mode, input logic ctim,
                         input logic al, input logic [15:0] count);
        req_ch      = ch;
        mode_reg    = mode;
        cmd_ctim    = ctim;
        cmd_dack_al = al;
        cnt         = count;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, d, w;
        logic [3:0] oh;

        drive(6'b001110);
        repeat (3) @(negedge CLK);
        check("reset outputs", act_w, IDLE0);
        check("reset state", {11'd0, state_dbg}, {11'd0, 3'(SI)});
        RESET = 1'b1;

        // single write ch2, HLDA two clocks after HRQ
        setup(2'd2, 8'h44, 1'b0, 1'b0, 16'd5);
        add(6'b101110, 14'b100_1111_100_0000);
        add(6'b101110, 14'b100_1111_100_0000);
        add(6'b111110, 14'b111_1111_100_0100);
        add(6'b111110, 14'b110_1011_100_0100);
        add(6'b111110, 14'b110_1001_100_0100);
        add(6'b111110, 14'b110_1111_110_0100);
        add(6'b011110, 14'b000_1111_101_0000);
        add(6'b001110, IDLE0);
        run_table("single_write");

        // block read ch0, three transfers, address high byte changes before the third
        setup(2'd0, 8'h88, 1'b0, 1'b0, 16'd2);
        add(6'b101110, 14'b100_1111_100_0000);
        add(6'b111110, 14'b111_1111_100_0001);
        add(6'b111110, 14'b110_0111_100_0001);
        add(6'b111110, 14'b110_0110_100_0001);
        add(6'b111110, 14'b110_1111_110_0001);
        add(6'b111110, 14'b110_1111_100_0001);
        add(6'b111110, 14'b110_0111_100_0001);
        add(6'b111110, 14'b110_0110_100_0001);
        add(6'b111110, 14'b110_1111_110_0001);
        add(6'b111111, 14'b111_1111_100_0001);
        add(6'b111110, 14'b110_0111_100_0001);
        add(6'b111110, 14'b110_0110_100_0001);
        add(6'b111110, 14'b110_1111_010_0001);
        add(6'b011110, 14'b000_1111_101_0000);
        add(6'b001110, IDLE0);
        run_table("block_read_tc");

        // single read ch1 with three wait states after S3
        setup(2'd1, 8'h48, 1'b0, 1'b0, 16'd5);
        add(6'b101110, 14'b100_1111_100_0000);
        add(6'b111110, 14'b111_1111_100_0010);
        add(6'b111110, 14'b110_0111_100_0010);
        add(6'b111110, 14'b110_0110_100_0010);
        add(6'b110110, 14'b110_0110_100_0010);
        add(6'b110110, 14'b110_0110_100_0010);
        add(6'b110110, 14'b110_0110_100_0010);
        add(6'b111110, 14'b110_1111_110_0010);
        add(6'b011110, 14'b000_1111_101_0000);
        add(6'b001110, IDLE0);
        run_table("ready_waits");

        // demand write ch1, compressed timing, DREQ drops in the second transfer
        setup(2'd1, 8'h04, 1'b1, 1'b0, 16'd5);
        add(6'b101110, 14'b100_1111_100_0000);
        add(6'b111110, 14'b111_1111_100_0010);
        add(6'b111110, 14'b110_1001_100_0010);
        add(6'b111110, 14'b110_1111_110_0010);
        add(6'b111110, 14'b110_1111_100_0010);
        add(6'b111010, 14'b110_1001_100_0010);
        add(6'b111010, 14'b110_1111_110_0010);
        add(6'b011010, 14'b000_1111_101_0000);
        add(6'b001110, IDLE0);
        run_table("demand_ctim");

        // block write ch3 ended by external EOP seen in S2; EOP in SI is ignored
        setup(2'd3, 8'h84, 1'b0, 1'b0, 16'd5);
        add(6'b001100, IDLE0);
        add(6'b101110, 14'b100_1111_100_0000);
        add(6'b111110, 14'b111_1111_100_1000);
        add(6'b111110, 14'b110_1011_100_1000);
        add(6'b111100, 14'b110_1001_100_1000);
        add(6'b111110, 14'b110_1111_110_1000);
        add(6'b011110, 14'b000_1111_101_0000);
        add(6'b001110, IDLE0);
        run_table("ext_eop");

        // HLDA lost in S2 aborts; then a request withdrawn while still in S0
        setup(2'd2, 8'h44, 1'b0, 1'b0, 16'd5);
        add(6'b101110, 14'b100_1111_100_0000);
        add(6'b111110, 14'b111_1111_100_0100);
        add(6'b111110, 14'b110_1011_100_0100);
        add(6'b101110, 14'b000_1111_101_0000);
        add(6'b001110, IDLE0);
        add(6'b101110, 14'b100_1111_100_0000);
        add(6'b001110, IDLE0);
        run_table("hlda_abort");

        // cascade ch3 with active-low DACK
        setup(2'd3, 8'hC0, 1'b0, 1'b1, 16'd5);
        add(6'b001110, 14'b000_1111_100_1111);
        add(6'b101110, 14'b100_1111_100_1111);
        add(6'b111110, 14'b100_1111_100_0111);
        add(6'b111110, 14'b100_1111_100_0111);
        add(6'b001110, 14'b000_1111_101_1111);
        add(6'b001110, 14'b000_1111_100_1111);
        run_table("cascade_al");
        cmd_dack_al = 1'b0;

        // randomized single verify transfers: HLDA delay and wait states vary
        for (int t = 0; t < 4; t++) begin
            c  = $urandom_range(0, 3);
            d  = $urandom_range(0, 2);
            w  = $urandom_range(0, 2);
            oh = 4'(1 << c);
            setup(c[1:0], 8'h40, 1'b0, 1'b0, 16'd20);
            add(6'b101110, 14'b100_1111_100_0000);
            for (int k = 0; k < d; k++) add(6'b101110, 14'b100_1111_100_0000);
            add(6'b111110, {10'b111_1111_100, oh});
            add(6'b111110, {10'b110_1111_100, oh});
            add(6'b111110, {10'b110_1111_100, oh});
            for (int k = 0; k < w; k++) add(6'b110110, {10'b110_1111_100, oh});
            add(6'b111110, {10'b110_1111_110, oh});
            add(6'b011110, 14'b000_1111_101_0000);
            add(6'b001110, IDLE0);
            run_table($sformatf("rand_verify%0d", t));
        end

        // asynchronous reset while the engine sits in SW
        setup(2'd1, 8'h48, 1'b0, 1'b0, 16'd5);
        add(6'b101110, 14'b100_1111_100_0000);
        add(6'b111110, 14'b111_1111_100_0010);
        add(6'b111110, 14'b110_0111_100_0010);
        add(6'b111110, 14'b110_0110_100_0010);
        add(6'b110110, 14'b110_0110_100_0010);
        run_table("pre_reset_sw");
        #2 RESET = 1'b0;
        #1;
        check("reset in SW outputs", act_w, IDLE0);
        check("reset in SW state", {11'd0, state_dbg}, {11'd0, 3'(SI)});
        drive(6'b001110);
        @(negedge CLK);
        RESET = 1'b1;
        add(6'b001110, IDLE0);
        add(6'b101110, 14'b100_1111_100_0000);
        add(6'b001110, IDLE0);
        run_table("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
